// File: rtl/ex_mem_pipe_reg_if.sv
// EX/MEM pipeline register bus: upstream beat, downstream head beat and the
// decoded control qualifiers. The block under control uses the slave view,
// whoever drives the pipeline stage uses the master view.
interface ex_mem_pipe_reg_if #(
    parameter int CTRL_W = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [CTRL_W-1:0] ctrl_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [DATA_W-1:0] alu_i;
    logic [DATA_W-1:0] store_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CTRL_W-1:0] ctrl_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [DATA_W-1:0] alu_o;
    logic [DATA_W-1:0] store_o;
    logic              regwrite_o;
    logic              memread_o;
    logic              memwrite_o;
    logic [1:0]        occupancy_o;

    modport slave (
        input  flush_i, in_valid_i, ctrl_i, rd_addr_i, alu_i, store_i, out_ready_i,
        output in_ready_o, out_valid_o, ctrl_o, rd_addr_o, alu_o, store_o,
               regwrite_o, memread_o, memwrite_o, occupancy_o
    );

    modport master (
        output flush_i, in_valid_i, ctrl_i, rd_addr_i, alu_i, store_i, out_ready_i,
        input  in_ready_o, out_valid_o, ctrl_o, rd_addr_o, alu_o, store_o,
               regwrite_o, memread_o, memwrite_o, occupancy_o
    );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready handshake, flush and an optional
// two-entry skid buffer. The main entry always presents the head beat; the
// skid entry only catches the beat that arrives while the head is stalled,
// which lets in_ready come straight from a flop in skid mode.
// The main control register is kept at zero whenever the main entry is empty,
// so a bubble can never assert RegWrite/MemRead/MemWrite downstream.
module ex_mem_pipe_reg #(
    parameter int CTRL_W = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int SKID   = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ex_mem_pipe_reg_if.slave   bus
);
    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic [ADDR_W-1:0] main_rd_q,    main_rd_d;
    logic [DATA_W-1:0] main_alu_q,   main_alu_d;
    logic [DATA_W-1:0] main_st_q,    main_st_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic [ADDR_W-1:0] skid_rd_q,    skid_rd_d;
    logic [DATA_W-1:0] skid_alu_q,   skid_alu_d;
    logic [DATA_W-1:0] skid_st_q,    skid_st_d;
    logic              in_ready_q,   in_ready_d;
    logic              in_ready_s;
    logic              in_fire_s;
    logic              out_fire_s;

    // Upstream ready: straight from a flop in skid mode, pass-through of the head otherwise
    always_comb begin
        if (SKID != 0) begin
            in_ready_s = in_ready_q;
        end else begin
            in_ready_s = ~main_valid_q | bus.out_ready_i;
        end
    end

    assign in_fire_s  = bus.in_valid_i & in_ready_s;
    assign out_fire_s = main_valid_q & bus.out_ready_i;

    // Next-state of both entries; flush wins over every handshake
    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_rd_d    = main_rd_q;
        main_alu_d   = main_alu_q;
        main_st_d    = main_st_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_rd_d    = skid_rd_q;
        skid_alu_d   = skid_alu_q;
        skid_st_d    = skid_st_q;
        if (bus.flush_i) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = {CTRL_W{1'b0}};
            skid_valid_d = 1'b0;
        end else if (SKID != 0) begin
            if (!main_valid_q) begin
                if (in_fire_s) begin
                    main_valid_d = 1'b1;
                    main_ctrl_d  = bus.ctrl_i;
                    main_rd_d    = bus.rd_addr_i;
                    main_alu_d   = bus.alu_i;
                    main_st_d    = bus.store_i;
                end else begin
                    main_valid_d = 1'b0;
                end
            end else if (out_fire_s) begin
                if (skid_valid_q) begin
                    main_ctrl_d  = skid_ctrl_q;
                    main_rd_d    = skid_rd_q;
                    main_alu_d   = skid_alu_q;
                    main_st_d    = skid_st_q;
                    skid_valid_d = 1'b0;
                end else if (in_fire_s) begin
                    main_ctrl_d  = bus.ctrl_i;
                    main_rd_d    = bus.rd_addr_i;
                    main_alu_d   = bus.alu_i;
                    main_st_d    = bus.store_i;
                end else begin
                    main_valid_d = 1'b0;
                    main_ctrl_d  = {CTRL_W{1'b0}};
                end
            end else if (in_fire_s) begin
                skid_valid_d = 1'b1;
                skid_ctrl_d  = bus.ctrl_i;
                skid_rd_d    = bus.rd_addr_i;
                skid_alu_d   = bus.alu_i;
                skid_st_d    = bus.store_i;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end else begin
            skid_valid_d = 1'b0;
            if (in_fire_s) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = bus.ctrl_i;
                main_rd_d    = bus.rd_addr_i;
                main_alu_d   = bus.alu_i;
                main_st_d    = bus.store_i;
            end else if (out_fire_s) begin
                main_valid_d = 1'b0;
                main_ctrl_d  = {CTRL_W{1'b0}};
            end else begin
                main_valid_d = main_valid_q;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    // State registers, cleared asynchronously; ready comes up asserted
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= {CTRL_W{1'b0}};
            main_rd_q    <= {ADDR_W{1'b0}};
            main_alu_q   <= {DATA_W{1'b0}};
            main_st_q    <= {DATA_W{1'b0}};
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= {CTRL_W{1'b0}};
            skid_rd_q    <= {ADDR_W{1'b0}};
            skid_alu_q   <= {DATA_W{1'b0}};
            skid_st_q    <= {DATA_W{1'b0}};
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_rd_q    <= main_rd_d;
            main_alu_q   <= main_alu_d;
            main_st_q    <= main_st_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_rd_q    <= skid_rd_d;
            skid_alu_q   <= skid_alu_d;
            skid_st_q    <= skid_st_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready_o  = in_ready_s;
    assign bus.out_valid_o = main_valid_q;
    assign bus.ctrl_o      = main_valid_q ? main_ctrl_q : {CTRL_W{1'b0}};
    assign bus.rd_addr_o   = main_rd_q;
    assign bus.alu_o       = main_alu_q;
    assign bus.store_o     = main_st_q;
    assign bus.regwrite_o  = bus.ctrl_o[0];
    assign bus.memread_o   = bus.ctrl_o[2];
    assign bus.memwrite_o  = bus.ctrl_o[3];
    assign bus.occupancy_o = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: one instance per storage mode, both driven by the
// same stimulus and each compared against a FIFO-queue reference model.
module tb_ex_mem_pipe_reg;
    typedef struct packed {
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] st;
    } beat_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush, in_valid, out_ready;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] alu, st;

    int err_cnt = 0;
    int chk_cnt = 0;
    beat_t q0[$];
    beat_t q1[$];

    ex_mem_pipe_reg_if #(.CTRL_W(4), .ADDR_W(5), .DATA_W(32)) bus0 ();
    ex_mem_pipe_reg_if #(.CTRL_W(4), .ADDR_W(5), .DATA_W(32)) bus1 ();

    ex_mem_pipe_reg #(.CTRL_W(4), .ADDR_W(5), .DATA_W(32), .SKID(0)) dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus0));
    ex_mem_pipe_reg #(.CTRL_W(4), .ADDR_W(5), .DATA_W(32), .SKID(1)) dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus1));

    assign bus0.flush_i = flush;      assign bus1.flush_i = flush;
    assign bus0.in_valid_i = in_valid; assign bus1.in_valid_i = in_valid;
    assign bus0.ctrl_i = ctrl;        assign bus1.ctrl_i = ctrl;
    assign bus0.rd_addr_i = rd;       assign bus1.rd_addr_i = rd;
    assign bus0.alu_i = alu;          assign bus1.alu_i = alu;
    assign bus0.store_i = st;         assign bus1.store_i = st;
    assign bus0.out_ready_i = out_ready; assign bus1.out_ready_i = out_ready;

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare one instance against the model: n beats held, head beat h
    task automatic check_port(input int skid, input int n, input beat_t h, input logic ordy,
                              input logic ov, input logic ir, input logic [1:0] occ,
                              input logic [3:0] c, input logic [4:0] r,
                              input logic [31:0] a, input logic [31:0] s,
                              input logic rw, input logic mr, input logic mw);
        logic       exp_ready;
        logic [3:0] exp_ctrl;
        exp_ready = (skid != 0) ? (n < 2) : (n == 0 || ordy);
        exp_ctrl  = (n != 0) ? h.ctrl : 4'd0;
        check_val($sformatf("s%0d_out_valid", skid), {63'd0, ov}, {63'd0, n != 0});
        check_val($sformatf("s%0d_in_ready", skid), {63'd0, ir}, {63'd0, exp_ready});
        check_val($sformatf("s%0d_occupancy", skid), {62'd0, occ}, 64'(n));
        check_val($sformatf("s%0d_ctrl", skid), {60'd0, c}, {60'd0, exp_ctrl});
        check_val($sformatf("s%0d_flags", skid), {61'd0, mw, mr, rw},
                  {61'd0, exp_ctrl[3], exp_ctrl[2], exp_ctrl[0]});
        if (n != 0) begin
            check_val($sformatf("s%0d_rd", skid), {59'd0, r}, {59'd0, h.rd});
            check_val($sformatf("s%0d_alu", skid), {32'd0, a}, {32'd0, h.alu});
            check_val($sformatf("s%0d_store", skid), {32'd0, s}, {32'd0, h.st});
        end
    endtask

    task automatic check_both(input logic ordy);
        beat_t h0, h1;
        h0 = {4'd0, 5'd0, 32'd0, 32'd0};
        h1 = {4'd0, 5'd0, 32'd0, 32'd0};
        if (q0.size() != 0) h0 = q0[0];
        if (q1.size() != 0) h1 = q1[0];
        check_port(0, q0.size(), h0, ordy, bus0.out_valid_o, bus0.in_ready_o, bus0.occupancy_o,
                   bus0.ctrl_o, bus0.rd_addr_o, bus0.alu_o, bus0.store_o,
                   bus0.regwrite_o, bus0.memread_o, bus0.memwrite_o);
        check_port(1, q1.size(), h1, ordy, bus1.out_valid_o, bus1.in_ready_o, bus1.occupancy_o,
                   bus1.ctrl_o, bus1.rd_addr_o, bus1.alu_o, bus1.store_o,
                   bus1.regwrite_o, bus1.memread_o, bus1.memwrite_o);
    endtask

    // One clock: drive at the falling edge, check, then advance the model at the rising edge
    task automatic step(input logic v, input logic [3:0] c, input logic [4:0] r,
                        input logic [31:0] a, input logic [31:0] s,
                        input logic ordy, input logic fl);
        beat_t b;
        logic  in0, in1, out0, out1;
        @(negedge clk_i);
        in_valid = v; ctrl = c; rd = r; alu = a; st = s; out_ready = ordy; flush = fl;
        #1;
        check_both(ordy);
        in0  = v && (q0.size() == 0 || ordy);
        in1  = v && (q1.size() < 2);
        out0 = (q0.size() != 0) && ordy;
        out1 = (q1.size() != 0) && ordy;
        b.ctrl = c; b.rd = r; b.alu = a; b.st = s;
        @(posedge clk_i);
        if (fl) begin
            q0.delete();
            q1.delete();
        end else begin
            if (out0) void'(q0.pop_front());
            if (in0) q0.push_back(b);
            if (out1) void'(q1.pop_front());
            if (in1) q1.push_back(b);
        end
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_s1_valid"}, {63'd0, bus1.out_valid_o}, 64'd0);
        check_val({tag, "_s1_ctrl"}, {60'd0, bus1.ctrl_o}, 64'd0);
        check_val({tag, "_s1_rd"}, {59'd0, bus1.rd_addr_o}, 64'd0);
        check_val({tag, "_s1_alu"}, {32'd0, bus1.alu_o}, 64'd0);
        check_val({tag, "_s1_store"}, {32'd0, bus1.store_o}, 64'd0);
        check_val({tag, "_s1_occ"}, {62'd0, bus1.occupancy_o}, 64'd0);
        check_val({tag, "_s1_ready"}, {63'd0, bus1.in_ready_o}, 64'd1);
        check_val({tag, "_s0_valid"}, {63'd0, bus0.out_valid_o}, 64'd0);
        check_val({tag, "_s0_ctrl"}, {60'd0, bus0.ctrl_o}, 64'd0);
        check_val({tag, "_s0_alu"}, {32'd0, bus0.alu_o}, 64'd0);
        check_val({tag, "_s0_occ"}, {62'd0, bus0.occupancy_o}, 64'd0);
    endtask

    initial begin
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ctrl = 4'd0; rd = 5'd0; alu = 32'd0; st = 32'd0;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_cleared("reset");
        @(negedge clk_i);
        rst_i = 1'b1;

        // First beat, one-cycle latency, decoded flags
        step(1'b1, 4'b1001, 5'd7, 32'h1234, 32'hABCD, 1'b1, 1'b0);
        #1;
        check_val("tp1_valid", {63'd0, bus1.out_valid_o}, 64'd1);
        check_val("tp1_ctrl", {60'd0, bus1.ctrl_o}, 64'd9);
        check_val("tp1_regwrite", {63'd0, bus1.regwrite_o}, 64'd1);
        check_val("tp1_memwrite", {63'd0, bus1.memwrite_o}, 64'd1);
        check_val("tp1_alu", {32'd0, bus1.alu_o}, 64'h1234);
        step(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Stall with A then B, then drain in order
        step(1'b1, 4'h1, 5'd1, 32'hA, 32'hA0, 1'b0, 1'b0);
        step(1'b1, 4'h4, 5'd2, 32'hB, 32'hB0, 1'b0, 1'b0);
        step(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Full throughput sequence 1..8
        for (int i = 1; i <= 8; i++)
            step(1'b1, 4'(i), 5'(i), 32'(i), 32'(i * 3), 1'b1, 1'b0);
        repeat (2) step(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Both entries full, then flush alongside an incoming beat
        step(1'b1, 4'hF, 5'd3, 32'h33, 32'h3, 1'b0, 1'b0);
        step(1'b1, 4'hD, 5'd4, 32'h44, 32'h4, 1'b0, 1'b0);
        step(1'b1, 4'hB, 5'd5, 32'h55, 32'h5, 1'b0, 1'b1);
        repeat (2) step(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Asynchronous reset with two beats held
        step(1'b1, 4'h9, 5'd6, 32'h66, 32'h6, 1'b0, 1'b0);
        step(1'b1, 4'hC, 5'd8, 32'h88, 32'h8, 1'b0, 1'b0);
        @(negedge clk_i);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check_val("pre_rst_occ", {62'd0, bus1.occupancy_o}, 64'd2);
        #1;
        rst_i = 1'b0;
        #1;
        check_cleared("async_rst");
        q0.delete();
        q1.delete();
        @(negedge clk_i);
        rst_i = 1'b1;

        // Head replaced in one cycle for the single-register mode
        step(1'b1, 4'h5, 5'd9, 32'h99, 32'h9, 1'b0, 1'b0);
        step(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 4'h8, 5'd10, 32'hAA, 32'h10, 1'b1, 1'b0);
        step(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom), 5'($urandom), $urandom, $urandom,
                 $urandom_range(0, 1) != 0, $urandom_range(0, 15) == 0);
        end
        step(1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- Parametrised successor to the fixed EX/MEM latch.
- Carries control, destination-register and datapath fields from EX to MEM under a valid/ready handshake, not a bare stall input.
- Supports pipeline flush and an optional two-entry skid buffer, so the upstream ready is fully registered.
- Control outputs are forced to zero whenever no valid beat is presented, so bubbles never write memory or the register file.

Parameters:
- CTRL_W, 4, control field width (min 4); bit0 RegWrite, bit1 MemToReg, bit2 MemRead, bit3 MemWrite, upper bits passed through.
- ADDR_W, 5, destination register address width.
- DATA_W, 32, width of the ALU result and store-data fields.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single register with combinational ready.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- flush_i  input  1  kill all held and incoming beats.
- in_valid_i  input  1  upstream beat valid.
- in_ready_o  output  1  block can accept a beat.
- ctrl_i  input  CTRL_W  control field.
- rd_addr_i  input  ADDR_W  destination register.
- alu_i  input  DATA_W  ALU result.
- store_i  input  DATA_W  store data.
- out_valid_o  output  1  head beat valid.
- out_ready_i  input  1  downstream accepts head beat.
- ctrl_o  output  CTRL_W  head control field, 0 when out_valid_o=0.
- rd_addr_o  output  ADDR_W  head destination register.
- alu_o  output  DATA_W  head ALU result.
- store_o  output  DATA_W  head store data.
- regwrite_o  output  1  ctrl_o[0]; forwarding qualifier.
- memread_o  output  1  ctrl_o[2].
- memwrite_o  output  1  ctrl_o[3].
- occupancy_o  output  2  beats held (0..2; max 1 when SKID=0).

Behaviour:
- Reset (rst_i=0, any time, asynchronous):
  - Main and skid valid bits cleared; all stored fields cleared to 0.
  - out_valid_o=0, ctrl_o=0, rd_addr_o=0, alu_o=0, store_o=0, occupancy_o=0.
  - in_ready_o=1 in both modes.
  - A handshake in progress when reset asserts is lost; it is not replayed.
- Handshakes:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
- Latency: 1 cycle from in_fire to out_valid_o when the block is empty.
- Ordering: strict FIFO; no beat is dropped or duplicated except by flush.
- Storage (SKID=1): main entry drives the outputs; skid entry holds overflow.
- SKID=1 transitions per clock edge, evaluated in this order:
  - Main empty, in_fire: main <= input.
  - Main full, out_fire, skid empty, in_fire: main <= input.
  - Main full, out_fire, skid empty, no in_fire: main empties.
  - Main full, out_fire, skid full: main <= skid, skid empties. in_ready_o is 0, so no in_fire is possible.
  - Main full, no out_fire, in_fire: skid <= input.
  - Otherwise: hold.
- in_ready_o (SKID=1): registered, equals ~skid_valid. It falls in the cycle after the skid fills and rises in the cycle after the skid drains.
- SKID=0:
  - Single entry; in_ready_o = ~out_valid_o | out_ready_i (combinational).
  - in_fire loads the entry; out_fire without in_fire empties it.
- Flush (flush_i=1 at an edge):
  - Both valid bits cleared; any in_fire in the same cycle is discarded.
  - Flush has priority over all handshakes.
  - Data fields may hold stale values, but ctrl_o reads 0 from the next cycle.
  - in_ready_o=1 the cycle after a flush.
- Bubble masking: ctrl_o = main_valid ? main_ctrl : 0. regwrite_o, memread_o and memwrite_o derive from the masked ctrl_o.
- Data under stall: while out_valid_o=1 and out_ready_i=0, all outputs are held stable.
- occupancy_o = main_valid + skid_valid.

Test Plan:
- Reset, then in_valid_i=1 with ctrl_i=4'b1001, rd_addr_i=7, alu_i=0x1234 and out_ready_i=1 -> next cycle out_valid_o=1, ctrl_o=9, regwrite_o=1, memwrite_o=1, alu_o=0x1234.
- SKID=1, out_ready_i=0, push A then B -> occupancy_o=2; in_ready_o=0 the cycle after B. Raise out_ready_i -> A then B emerge on consecutive cycles; in_ready_o returns to 1 after B moves to main.
- Full throughput: in_valid_i=1 and out_ready_i=1 with sequence 1..8 -> outputs 1..8 one per cycle, occupancy_o never exceeds 1.
- Both entries full, then flush_i=1 together with in_valid_i=1 -> next cycle out_valid_o=0, ctrl_o=0, occupancy_o=0, in_ready_o=1; the flushed beats and the incoming beat never appear.
- Apply rst_i=0 mid-stall with two beats held -> outputs clear to 0 immediately, without waiting for a clock edge.
- SKID=0 with out_ready_i=0 and main full -> in_ready_o=0 combinationally. Raise out_ready_i with in_valid_i=1 -> head replaced in one cycle, with no bubble.
